// File: rtl/axi2ahb_pkg.sv
// ----------------------------------------------------------------------------
// axi2ahb_pkg : AHB/AXI encodings and bridge state types
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi2ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [1:0] AXI_OKAY      = 2'b00;
  localparam logic [1:0] AXI_SLVERR    = 2'b10;
  localparam logic [1:0] AXI_DECERR    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_BRESP = 3'd3,
    ST_RRESP = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/axi2ahb_if.sv
// ----------------------------------------------------------------------------
// axi2ahb_if : AXI4-Lite and AHB-Lite bus bundles used by the bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface axi2ahb_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface axi2ahb_ahb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready_in;
  logic              hready_resp;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
    output hready_resp, hresp, hrdata
  );
endinterface

`default_nettype wire

// File: rtl/axi2ahb_strb_dec.sv
// ----------------------------------------------------------------------------
// axi2ahb_strb_dec : maps a write strobe to AHB hsize and byte address
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi2ahb_strb_dec
  import axi2ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:2] addr_hi,
  output logic [ADDR_W-1:0] haddr,
  output logic [2:0]        hsize,
  output logic              illegal
);

  always_comb begin
    haddr   = {addr_hi, 2'b00};
    hsize   = HSIZE_WORD;
    illegal = 1'b0;
    case (wstrb)
      4'b1111: hsize = HSIZE_WORD;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin hsize = HSIZE_HALF; haddr[1:0] = 2'b10; end
      4'b0001: begin hsize = HSIZE_BYTE; haddr[1:0] = 2'b00; end
      4'b0010: begin hsize = HSIZE_BYTE; haddr[1:0] = 2'b01; end
      4'b0100: begin hsize = HSIZE_BYTE; haddr[1:0] = 2'b10; end
      4'b1000: begin hsize = HSIZE_BYTE; haddr[1:0] = 2'b11; end
      // Sparse or empty strobes cannot be expressed as one AHB transfer.
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi2ahb_bridge.sv
// ----------------------------------------------------------------------------
// axi2ahb_bridge : AXI4-Lite slave to AHB-Lite master, one NONSEQ per access
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi2ahb_bridge
  import axi2ahb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 65536
) (
  input  logic          hclk,
  input  logic          hreset,
  axi2ahb_axi_if.slave  axi,
  axi2ahb_ahb_if.master ahb
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e              state_q,     state_d;
  grant_e              last_grant_q, last_grant_d;
  logic                wr_ready_q,  wr_ready_d;
  logic                rd_ready_q,  rd_ready_d;
  logic                bvalid_q,    bvalid_d;
  logic                rvalid_q,    rvalid_d;
  logic [1:0]          bresp_q,     bresp_d;
  logic [1:0]          rresp_q,     rresp_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;
  logic                hsel_q,      hsel_d;
  logic [1:0]          htrans_q,    htrans_d;
  logic                hwrite_q,    hwrite_d;
  logic [ADDR_W-1:0]   haddr_q,     haddr_d;
  logic [2:0]          hsize_q,     hsize_d;
  logic [DATA_W-1:0]   hwdata_q,    hwdata_d;
  logic                err_q,       err_d;

  logic [ADDR_W-1:0]   dec_haddr;
  logic [2:0]          dec_hsize;
  logic                dec_illegal;
  logic                wr_out_of_range;
  logic                rd_out_of_range;
  logic                wr_cand;
  logic                rd_cand;
  logic                data_err;

  axi2ahb_strb_dec #(.ADDR_W(ADDR_W)) u_strb_dec (
    .wstrb   (axi.wstrb),
    .addr_hi (axi.awaddr[ADDR_W-1:2]),
    .haddr   (dec_haddr),
    .hsize   (dec_hsize),
    .illegal (dec_illegal)
  );

  assign wr_out_of_range = ({1'b0, axi.awaddr} >= MEM_LIMIT);
  assign rd_out_of_range = ({1'b0, axi.araddr} >= MEM_LIMIT);
  assign wr_cand         = axi.awvalid & axi.wvalid;
  assign rd_cand         = axi.arvalid;
  assign data_err        = (ahb.hresp == HRESP_ERROR);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_ready_d   = 1'b0;
    rd_ready_d   = 1'b0;
    bvalid_d     = bvalid_q;
    rvalid_d     = rvalid_q;
    bresp_d      = bresp_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    hsel_d       = hsel_q;
    htrans_d     = htrans_q;
    hwrite_d     = hwrite_q;
    haddr_d      = haddr_q;
    hsize_d      = hsize_q;
    hwdata_d     = hwdata_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        // Ready was raised last cycle and valid is held, so this cycle is the handshake.
        if (wr_ready_q) begin
          hwrite_d = 1'b1;
          haddr_d  = dec_haddr;
          hsize_d  = dec_hsize;
          hwdata_d = axi.wdata;
          if (dec_illegal) begin
            bresp_d  = AXI_SLVERR;
            bvalid_d = 1'b1;
            state_d  = ST_BRESP;
          end else if (wr_out_of_range) begin
            bresp_d  = AXI_DECERR;
            bvalid_d = 1'b1;
            state_d  = ST_BRESP;
          end else begin
            hsel_d   = 1'b1;
            htrans_d = HTRANS_NONSEQ;
            state_d  = ST_ADDR;
          end
        end else if (rd_ready_q) begin
          hwrite_d = 1'b0;
          haddr_d  = {axi.araddr[ADDR_W-1:2], 2'b00};
          hsize_d  = HSIZE_WORD;
          if (rd_out_of_range) begin
            rresp_d  = AXI_DECERR;
            rvalid_d = 1'b1;
            state_d  = ST_RRESP;
          end else begin
            hsel_d   = 1'b1;
            htrans_d = HTRANS_NONSEQ;
            state_d  = ST_ADDR;
          end
        end else if (wr_cand && (!rd_cand || last_grant_q == GRANT_READ)) begin
          wr_ready_d   = 1'b1;
          last_grant_d = GRANT_WRITE;
        end else if (rd_cand) begin
          rd_ready_d   = 1'b1;
          last_grant_d = GRANT_READ;
        end
      end

      ST_ADDR: begin
        if (ahb.hready_resp) begin
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        if (data_err) begin
          err_d = 1'b1;
        end
        if (ahb.hready_resp) begin
          if (hwrite_q) begin
            bresp_d  = (err_q || data_err) ? AXI_SLVERR : AXI_OKAY;
            bvalid_d = 1'b1;
            state_d  = ST_BRESP;
          end else begin
            rdata_d  = ahb.hrdata;
            rresp_d  = (err_q || data_err) ? AXI_SLVERR : AXI_OKAY;
            rvalid_d = 1'b1;
            state_d  = ST_RRESP;
          end
        end
      end

      ST_BRESP: begin
        if (axi.bready) begin
          bvalid_d = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_RRESP: begin
        if (axi.rready) begin
          rvalid_d = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
      wr_ready_q   <= 1'b0;
      rd_ready_q   <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      rresp_q      <= 2'b00;
      rdata_q      <= '0;
      hsel_q       <= 1'b0;
      htrans_q     <= HTRANS_IDLE;
      hwrite_q     <= 1'b0;
      haddr_q      <= '0;
      hsize_q      <= 3'b000;
      hwdata_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ready_q   <= wr_ready_d;
      rd_ready_q   <= rd_ready_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      hsel_q       <= hsel_d;
      htrans_q     <= htrans_d;
      hwrite_q     <= hwrite_d;
      haddr_q      <= haddr_d;
      hsize_q      <= hsize_d;
      hwdata_q     <= hwdata_d;
      err_q        <= err_d;
    end
  end

  assign axi.awready   = wr_ready_q;
  assign axi.wready    = wr_ready_q;
  assign axi.arready   = rd_ready_q;
  assign axi.bvalid    = bvalid_q;
  assign axi.bresp     = bresp_q;
  assign axi.rvalid    = rvalid_q;
  assign axi.rresp     = rresp_q;
  assign axi.rdata     = rdata_q;

  assign ahb.hsel      = hsel_q;
  assign ahb.haddr     = haddr_q;
  assign ahb.htrans    = htrans_q;
  assign ahb.hwrite    = hwrite_q;
  assign ahb.hsize     = hsize_q;
  assign ahb.hburst    = HBURST_SINGLE;
  assign ahb.hwdata    = hwdata_q;
  assign ahb.hready_in = ahb.hready_resp;

endmodule

`default_nettype wire

// File: tb/tb_axi2ahb_bridge.sv
// ----------------------------------------------------------------------------
// tb_axi2ahb_bridge : directed self-checking bench for axi2ahb_bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axi2ahb_bridge;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  axi2ahb_axi_if #(.ADDR_W(32), .DATA_W(32)) axi ();
  axi2ahb_ahb_if #(.ADDR_W(32), .DATA_W(32)) ahb ();

  axi2ahb_bridge #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(65536)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .axi    (axi),
    .ahb    (ahb)
  );

  int tests = 0;
  int fails = 0;
  int hsel_cnt = 0;

  // Minimal AHB slave: word memory written at data-phase completion.
  logic [31:0] mem [0:255];
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr  = 32'h0;

  always @(posedge hclk) begin
    if (ahb.hsel) hsel_cnt <= hsel_cnt + 1;
    if (hreset) begin
      dp_valid <= 1'b0;
    end else if (ahb.hready_resp) begin
      if (dp_valid && dp_write) mem[dp_addr[9:2]] <= ahb.hwdata;
      dp_valid <= ahb.hsel && (ahb.htrans == 2'b10);
      dp_addr  <= ahb.haddr;
      dp_write <= ahb.hwrite;
    end
  end

  assign ahb.hrdata = (dp_valid && !dp_write) ? mem[dp_addr[9:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Returns in the address-phase cycle (T+1) with valids dropped.
  task automatic wr_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    while (!axi.awready && n < 20) begin tick(); n++; end
    chk("wr_grant", 32'(axi.awready), 32'd1);
    chk("wready_with_awready", 32'(axi.wready), 32'd1);
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic rd_start(input logic [31:0] a);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    while (!axi.arready && n < 20) begin tick(); n++; end
    chk("rd_grant", 32'(axi.arready), 32'd1);
    tick();
    axi.arvalid = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] resp);
    int n = 0;
    while (!axi.bvalid && n < 20) begin tick(); n++; end
    chk("bvalid", 32'(axi.bvalid), 32'd1);
    chk("bresp", 32'(axi.bresp), 32'(resp));
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    chk("bvalid_clr", 32'(axi.bvalid), 32'd0);
  endtask

  task automatic wait_r(input logic [1:0] resp, input logic [31:0] data, input bit check_data);
    int n = 0;
    while (!axi.rvalid && n < 20) begin tick(); n++; end
    chk("rvalid", 32'(axi.rvalid), 32'd1);
    chk("rresp", 32'(axi.rresp), 32'(resp));
    if (check_data) chk("rdata", axi.rdata, data);
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    chk("rvalid_clr", 32'(axi.rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit  exp_w;
    bit  saw_rvalid;

    hreset = 1'b1;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    ahb.hready_resp = 1'b1; ahb.hresp = 2'b00;
    tick(); tick();

    // Reset values
    chk("rst_awready", 32'(axi.awready), 32'd0);
    chk("rst_wready",  32'(axi.wready),  32'd0);
    chk("rst_arready", 32'(axi.arready), 32'd0);
    chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
    chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
    chk("rst_bresp",   32'(axi.bresp),   32'd0);
    chk("rst_rresp",   32'(axi.rresp),   32'd0);
    chk("rst_rdata",   axi.rdata,        32'd0);
    chk("rst_hsel",    32'(ahb.hsel),    32'd0);
    chk("rst_htrans",  32'(ahb.htrans),  32'd0);
    chk("rst_hwrite",  32'(ahb.hwrite),  32'd0);
    chk("rst_haddr",   ahb.haddr,        32'd0);
    chk("rst_hsize",   32'(ahb.hsize),   32'd0);
    chk("rst_hwdata",  ahb.hwdata,       32'd0);
    ahb.hready_resp = 1'b0; #1;
    chk("rst_hready_in_lo", 32'(ahb.hready_in), 32'd0);
    ahb.hready_resp = 1'b1; #1;
    chk("rst_hready_in_hi", 32'(ahb.hready_in), 32'd1);
    hreset = 1'b0;
    tick();

    // Arbitration with both sides pending every time: W,R,W,R
    for (int i = 0; i < 4; i++) begin
      axi.awaddr = 32'h40; axi.wdata = 32'h1000 + i; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      axi.araddr = 32'h40; axi.arvalid = 1'b1;
      cnt = 0;
      while (!(axi.awready || axi.arready) && cnt < 20) begin tick(); cnt++; end
      exp_w = (i % 2 == 0);
      chk("arb_awready", 32'(axi.awready), 32'(exp_w));
      chk("arb_arready", 32'(axi.arready), 32'(!exp_w));
      if (axi.awready) begin
        tick(); axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        wait_b(2'b00);
      end else begin
        tick(); axi.arvalid = 1'b0;
        wait_r(2'b00, 32'h1000 + i - 1, 1'b1);
      end
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    tick();

    // Word write, zero-wait latency
    wr_start(32'h10, 32'hDEADBEEF, 4'b1111);
    chk("w_t1_hsel",   32'(ahb.hsel),   32'd1);
    chk("w_t1_htrans", 32'(ahb.htrans), 32'h2);
    chk("w_t1_hwrite", 32'(ahb.hwrite), 32'd1);
    chk("w_t1_haddr",  ahb.haddr,       32'h10);
    chk("w_t1_hsize",  32'(ahb.hsize),  32'h2);
    chk("w_t1_hburst", 32'(ahb.hburst), 32'h0);
    chk("w_t1_awready", 32'(axi.awready), 32'd0);
    tick();
    chk("w_t2_hsel",   32'(ahb.hsel),   32'd0);
    chk("w_t2_htrans", 32'(ahb.htrans), 32'h0);
    chk("w_t2_hwdata", ahb.hwdata,      32'hDEADBEEF);
    chk("w_t2_bvalid", 32'(axi.bvalid), 32'd0);
    tick();
    chk("w_t3_bvalid", 32'(axi.bvalid), 32'd1);
    wait_b(2'b00);

    // Word read back
    rd_start(32'h10);
    chk("r_t1_hsel",   32'(ahb.hsel),   32'd1);
    chk("r_t1_hwrite", 32'(ahb.hwrite), 32'd0);
    chk("r_t1_haddr",  ahb.haddr,       32'h10);
    chk("r_t1_hsize",  32'(ahb.hsize),  32'h2);
    tick();
    chk("r_t2_rvalid", 32'(axi.rvalid), 32'd0);
    tick();
    chk("r_t3_rvalid", 32'(axi.rvalid), 32'd1);
    wait_r(2'b00, 32'hDEADBEEF, 1'b1);

    // Byte and halfword strobes
    wr_start(32'h20, 32'h11223344, 4'b0100);
    chk("byte_haddr", ahb.haddr,      32'h22);
    chk("byte_hsize", 32'(ahb.hsize), 32'h0);
    wait_b(2'b00);
    wr_start(32'h20, 32'h55667788, 4'b1100);
    chk("half_haddr", ahb.haddr,      32'h22);
    chk("half_hsize", 32'(ahb.hsize), 32'h1);
    wait_b(2'b00);

    // Illegal strobe: SLVERR, no AHB select
    cnt = hsel_cnt;
    wr_start(32'h20, 32'h0, 4'b0101);
    wait_b(2'b10);
    chk("illegal_no_hsel", 32'(hsel_cnt), 32'(cnt));

    // Three data-phase wait states
    wr_start(32'h30, 32'hCAFEF00D, 4'b1111);
    tick();
    ahb.hready_resp = 1'b0;
    #1;
    chk("ws_hready_in", 32'(ahb.hready_in), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("ws_hwdata", ahb.hwdata,      32'hCAFEF00D);
      chk("ws_bvalid", 32'(axi.bvalid), 32'd0);
      tick();
    end
    ahb.hready_resp = 1'b1;
    chk("ws_t5_hwdata", ahb.hwdata,      32'hCAFEF00D);
    chk("ws_t5_bvalid", 32'(axi.bvalid), 32'd0);
    tick();
    chk("ws_t6_bvalid", 32'(axi.bvalid), 32'd1);
    wait_b(2'b00);

    // Two-cycle AHB ERROR on a read
    rd_start(32'h10);
    tick();
    ahb.hresp = 2'b01; ahb.hready_resp = 1'b0;
    tick();
    ahb.hresp = 2'b01; ahb.hready_resp = 1'b1;
    tick();
    ahb.hresp = 2'b00;
    chk("err_rvalid", 32'(axi.rvalid), 32'd1);
    wait_r(2'b10, 32'h0, 1'b0);

    // Error flag must not leak into the next access
    rd_start(32'h10);
    wait_r(2'b00, 32'hDEADBEEF, 1'b1);

    // Out-of-range address: DECERR, no AHB select
    cnt = hsel_cnt;
    wr_start(32'h10000, 32'h12345678, 4'b1111);
    wait_b(2'b11);
    rd_start(32'h10000);
    wait_r(2'b11, 32'h0, 1'b0);
    chk("decerr_no_hsel", 32'(hsel_cnt), 32'(cnt));

    // Reset during the data phase
    rd_start(32'h14);
    tick();
    hreset = 1'b1;
    #1;
    chk("mid_rst_hsel",   32'(ahb.hsel),   32'd0);
    chk("mid_rst_htrans", 32'(ahb.htrans), 32'd0);
    chk("mid_rst_haddr",  ahb.haddr,       32'd0);
    chk("mid_rst_hsize",  32'(ahb.hsize),  32'd0);
    chk("mid_rst_hwdata", ahb.hwdata,      32'd0);
    chk("mid_rst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("mid_rst_rdata",  axi.rdata,       32'd0);
    tick();
    hreset = 1'b0;
    saw_rvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (axi.rvalid) saw_rvalid = 1'b1;
    end
    chk("mid_rst_no_rvalid", 32'(saw_rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
